alu_share_arb: RTL and testbench

Two-port arbiter that shares a single combinational `alu` instance between two requesters, for example the core execute stage and a coprocessor/debug port. Each requester supplies an operand pair and an `instruction_s` opcode with a valid/ready handshake. The block registers the winning request into a one-deep issue stage that drives the ALU, then captures `result_o`/`jump_now_o` into a per-requester response buffer drained by a valid/ready handshake. It sits between the requesters and the `alu` ports; the ALU itself stays unchanged.

---
 rtl/alu_share_arb.sv | 150 +++++++++++++++
 tb/tb_alu_share_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters through a one-deep issue stage
// and per-requester response buffers. Define ALU_ARB_FIXED_PRIO_EN to select fixed priority.
module alu_share_arb #(
  parameter int unsigned OP_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [63:0]       req_rd_i,
  input  logic [63:0]       req_rs_i,
  input  logic [2*OP_W-1:0] req_op_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [63:0]       resp_result_o,
  output logic [1:0]        resp_jump_o,
  output logic [31:0]       alu_rd_o,
  output logic [31:0]       alu_rs_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [31:0]       alu_result_i,
  input  logic              alu_jump_i,
  output logic              busy_o
);

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e     state_q [N_REQ];
  state_e     state_d [N_REQ];
  logic [1:0] elig;
  logic [1:0] grant;
  logic       accept;
  logic       win;
  logic       owner_q;

  // Eligibility and arbitration; a requester with an operation in flight is never eligible
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      elig[k] = req_valid_i[k] && (state_q[k] == S_IDLE);
    end
    grant = 2'b00;
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end
`else
  logic last_grant_q;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      elig[k] = req_valid_i[k] && (state_q[k] == S_IDLE);
    end
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= win;
    end
  end
`endif

  assign req_ready_o = grant;
  assign accept      = |grant;
  assign win         = grant[1];

  // Per-requester FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        state_q[k] <= S_IDLE;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Per-requester FSM next state
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        S_IDLE:   if (grant[k]) state_d[k] = S_ISSUED;
        S_ISSUED: if (busy_o && (owner_q == 1'(k))) state_d[k] = S_RESP;
        S_RESP:   if (resp_ready_i[k]) state_d[k] = S_IDLE;
        default:  state_d[k] = S_IDLE;
      endcase
    end
  end

  // Per-requester FSM outputs
  always_comb begin
    resp_valid_o = 2'b00;
    for (int k = 0; k < N_REQ; k++) begin
      resp_valid_o[k] = (state_q[k] == S_RESP);
    end
  end

  // Issue stage: operands hold their last value while the stage is empty
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy_o   <= 1'b0;
      owner_q  <= 1'b0;
      alu_rd_o <= '0;
      alu_rs_o <= '0;
      alu_op_o <= '0;
    end else begin
      busy_o <= accept;
      if (accept) begin
        owner_q  <= win;
        alu_rd_o <= win ? req_rd_i[2*DATA_W-1:DATA_W] : req_rd_i[DATA_W-1:0];
        alu_rs_o <= win ? req_rs_i[2*DATA_W-1:DATA_W] : req_rs_i[DATA_W-1:0];
        alu_op_o <= win ? req_op_i[2*OP_W-1:OP_W] : req_op_i[OP_W-1:0];
      end
    end
  end

  // Capture the ALU output into the owner's response buffer
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      resp_result_o <= '0;
      resp_jump_o   <= 2'b00;
    end else if (busy_o) begin
      if (owner_q) begin
        resp_result_o[2*DATA_W-1:DATA_W] <= alu_result_i;
        resp_jump_o[1]                   <= alu_jump_i;
      end else begin
        resp_result_o[DATA_W-1:0] <= alu_result_i;
        resp_jump_o[0]            <= alu_jump_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a small stand-in ALU and a
// transaction-level reference model (outstanding flags plus accept timestamps).
module tb_alu_share_arb;

  localparam int unsigned OP_W = 16;
  localparam logic [15:0] K_ADDU = 16'h0001;
  localparam logic [15:0] K_SUBU = 16'h0002;
  localparam logic [15:0] K_AND  = 16'h0003;
  localparam logic [15:0] K_BEQZ = 16'h0010;
  localparam logic [15:0] K_XOR  = 16'h00FF;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [63:0]       req_rd;
  logic [63:0]       req_rs;
  logic [2*OP_W-1:0] req_op;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [63:0]       resp_result;
  logic [1:0]        resp_jump;
  logic [31:0]       alu_rd;
  logic [31:0]       alu_rs;
  logic [OP_W-1:0]   alu_op;
  logic [31:0]       alu_result;
  logic              alu_jump;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic        m_out [2];
  int          m_acc [2];
  logic [31:0] m_res [2];
  logic        m_jmp [2];
  logic [31:0] m_shown_res [2];
  logic        m_shown_jmp [2];
  logic [31:0] m_rd, m_rs;
  logic [15:0] m_op;
  logic        m_busy;
  logic        m_last;

  always #5 clk = ~clk;

  alu_share_arb #(.OP_W(OP_W)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rd_i     (req_rd),
    .req_rs_i     (req_rs),
    .req_op_i     (req_op),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_result_o(resp_result),
    .resp_jump_o  (resp_jump),
    .alu_rd_o     (alu_rd),
    .alu_rs_o     (alu_rs),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .alu_jump_i   (alu_jump),
    .busy_o       (busy)
  );

  // Stand-in combinational ALU
  always_comb begin
    alu_result = 32'h0;
    alu_jump   = 1'b0;
    case (alu_op)
      K_ADDU:  alu_result = alu_rd + alu_rs;
      K_SUBU:  alu_result = alu_rd - alu_rs;
      K_AND:   alu_result = alu_rd & alu_rs;
      K_BEQZ:  alu_jump   = (alu_rd == 32'h0);
      default: alu_result = alu_rd ^ alu_rs;
    endcase
  end

  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] op);
    logic [31:0] r;
    case (op)
      K_ADDU:  begin r = a + b; return {1'b0, r}; end
      K_SUBU:  begin r = a - b; return {1'b0, r}; end
      K_AND:   return {1'b0, a & b};
      K_BEQZ:  return {(a == 32'h0), 32'h0};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 1'b0;
      m_acc[i] = 0;
      m_res[i] = '0;
      m_jmp[i] = 1'b0;
      m_shown_res[i] = '0;
      m_shown_jmp[i] = 1'b0;
    end
    m_rd = '0; m_rs = '0; m_op = '0;
    m_busy = 1'b0;
    m_last = 1'b1;
    cyc = 0;
  endtask

  // Check the current cycle against the model, then advance one clock to the next negedge
  task automatic step(output logic [1:0] g);
    logic [1:0]  elig;
    logic [1:0]  rv;
    logic [32:0] r;
    int          k;
    #1;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && !m_out[i];
      rv[i]   = m_out[i] && (cyc >= m_acc[i] + 2);
    end
    g = elig;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (elig == 2'b11) g = 2'b01;
`else
    if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
`endif
    chk("req_ready", 64'(req_ready), 64'(g));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("alu_rd", 64'(alu_rd), 64'(m_rd));
    chk("alu_rs", 64'(alu_rs), 64'(m_rs));
    chk("alu_op", 64'(alu_op), 64'(m_op));
    chk("resp_valid", 64'(resp_valid), 64'(rv));
    chk("resp_result", resp_result, {m_shown_res[1], m_shown_res[0]});
    chk("resp_jump", 64'(resp_jump), 64'({m_shown_jmp[1], m_shown_jmp[0]}));
    for (int i = 0; i < 2; i++) begin
      if (rv[i] && resp_ready[i]) m_out[i] = 1'b0;
      if (m_out[i] && (cyc + 1 == m_acc[i] + 2)) begin
        m_shown_res[i] = m_res[i];
        m_shown_jmp[i] = m_jmp[i];
      end
    end
    if (g != 2'b00) begin
      k = g[1] ? 1 : 0;
      m_out[k] = 1'b1;
      m_acc[k] = cyc;
      m_rd = req_rd[32*k +: 32];
      m_rs = req_rs[32*k +: 32];
      m_op = req_op[16*k +: 16];
      r = alu_ref(m_rd, m_rs, m_op);
      m_res[k] = r[31:0];
      m_jmp[k] = r[32];
      m_last = g[1];
    end
    m_busy = (g != 2'b00);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    logic [1:0] g;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    repeat (4) step(g);
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int          req;
    logic [31:0] rd;
    logic [31:0] rs;
    logic [15:0] op;
    logic [31:0] exp_res;
    logic        exp_jmp;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] op_pool [5];

  initial begin
    logic [1:0]  g;
    logic [1:0]  exp_rdy [6];
    logic        exp_busy [6];
    logic [1:0]  held;
    int          k;

    vecs[0] = '{0, 32'd5,        32'd3,        K_ADDU, 32'd8,       1'b0};
    vecs[1] = '{1, 32'd0,        32'd7,        K_BEQZ, 32'd0,       1'b1};
    vecs[2] = '{1, 32'd10,       32'd4,        K_SUBU, 32'd6,       1'b0};
    vecs[3] = '{0, 32'h0000F0F0, 32'h00000FF0, K_AND,  32'h000000F0, 1'b0};
    vecs[4] = '{0, 32'd3,        32'd0,        K_BEQZ, 32'd0,       1'b0};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'd1,        K_ADDU, 32'd0,       1'b0};
    op_pool = '{K_ADDU, K_SUBU, K_AND, K_BEQZ, K_XOR};

    // Reset values
    n_reset = 1'b0;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_rd = '0; req_rs = '0; req_op = '0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_result", resp_result, 64'(0));
    chk("rst_alu_rd", 64'(alu_rd), 64'(0));
    @(negedge clk);
    apply_reset();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      k = vecs[i].req;
      req_rd[32*k +: 32] = vecs[i].rd;
      req_rs[32*k +: 32] = vecs[i].rs;
      req_op[16*k +: 16] = vecs[i].op;
      req_valid = 2'b00;
      req_valid[k] = 1'b1;
      resp_ready = 2'b00;
      #1;
      chk("tbl_ready", 64'(req_ready), 64'(req_valid));
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("tbl_alu_rd", 64'(alu_rd), 64'(vecs[i].rd));
      chk("tbl_alu_rs", 64'(alu_rs), 64'(vecs[i].rs));
      chk("tbl_alu_op", 64'(alu_op), 64'(vecs[i].op));
      chk("tbl_busy", 64'(busy), 64'(1));
      chk("tbl_resp_early", 64'(resp_valid), 64'(0));
      @(negedge clk);
      #1;
      chk("tbl_resp_valid", 64'(resp_valid), 64'(2'b01 << k));
      chk("tbl_result", 64'(resp_result[32*k +: 32]), 64'(vecs[i].exp_res));
      chk("tbl_jump", 64'(resp_jump[k]), 64'(vecs[i].exp_jmp));
      chk("tbl_busy_clr", 64'(busy), 64'(0));
      resp_ready[k] = 1'b1;
      @(negedge clk);
      resp_ready = 2'b00;
      #1;
      chk("tbl_resp_done", 64'(resp_valid), 64'(0));
      chk("tbl_result_hold", 64'(resp_result[32*k +: 32]), 64'(vecs[i].exp_res));
      @(negedge clk);
    end

    // Both requesters valid every cycle from reset
    apply_reset();
    exp_rdy  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    req_rd = {32'd100, 32'd20};
    req_rs = {32'd1, 32'd2};
    req_op = {K_SUBU, K_ADDU};
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(exp_rdy[i]));
      chk("rr_busy", 64'(busy), 64'(exp_busy[i]));
      step(g);
    end
    drain();

    // Backpressure on requester 0 while requester 1 keeps completing
    req_rd[31:0] = 32'd7; req_rs[31:0] = 32'd9; req_op[15:0] = K_ADDU;
    req_valid = 2'b11;
    resp_ready = 2'b10;
    for (int i = 0; i < 14; i++) begin
      step(g);
      if (g[1]) begin
        req_rd[63:32] = $urandom;
        req_rs[63:32] = $urandom;
        req_op[31:16] = op_pool[$urandom_range(0, 4)];
      end
      if (i > 1) begin
        #1;
        chk("bp_ready0", 64'(req_ready[0]), 64'(0));
        #1;
      end
    end
    drain();

    // Asynchronous reset in the cycle after an accept
    req_rd[31:0] = 32'h1234; req_rs[31:0] = 32'h1; req_op[15:0] = K_ADDU;
    req_valid = 2'b01;
    resp_ready = 2'b00;
    step(g);
    req_valid = 2'b00;
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_alu_rd", 64'(alu_rd), 64'(0));
    chk("mid_rst_alu_op", 64'(alu_op), 64'(0));
    chk("mid_rst_result", resp_result, 64'(0));
    chk("mid_rst_jump", 64'(resp_jump), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    chk("post_rst_tie", 64'(req_ready), 64'(2'b01));
    for (int i = 0; i < 6; i++) step(g);
    drain();

    // Randomized traffic against the reference model
    held = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!held[j]) begin
          req_valid[j] = ($urandom_range(0, 9) < 7);
          req_rd[32*j +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          req_rs[32*j +: 32] = $urandom;
          req_op[16*j +: 16] = op_pool[$urandom_range(0, 4)];
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
      step(g);
      held = req_valid & ~g;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
